// File: rtl/signed_search_sar.sv
// Successive-approximation search that drives a signed comparator's A operand
// and narrows a WIDTH+1-bit signed [lo, hi] window until the target is found.
module signed_search_sar #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] lo_init,
  input  logic [WIDTH-1:0] hi_init,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_g,
  input  logic             cmp_q,
  input  logic             cmp_l,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    probes
);

  typedef enum logic [1:0] {IDLE, CALC, EVAL, FIN} state_t;

  localparam logic [2:0] RESP_G = 3'b100;
  localparam logic [2:0] RESP_Q = 3'b010;
  localparam logic [2:0] RESP_L = 3'b001;

  state_t state, state_n;

  logic signed [WIDTH:0]   lo, hi;
  logic signed [WIDTH:0]   lo_n, hi_n;
  logic signed [WIDTH:0]   cur;
  logic signed [WIDTH+1:0] sum;
  logic signed [WIDTH:0]   mid;
  logic [2:0]              resp;
  logic                    empty;
  logic                    exhausted;

  assign resp  = {cmp_g, cmp_q, cmp_l};
  assign cur   = {probe[WIDTH-1], probe};
  assign empty = (lo > hi);
  assign done  = (state == FIN);

  // Dropping the LSB of the widened sum is an arithmetic shift, i.e. floor((lo+hi)/2).
  assign sum = {lo[WIDTH], lo} + {hi[WIDTH], hi};
  assign mid = sum[WIDTH+1:1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lo_n = lo;
    hi_n = hi;
    if (resp == RESP_G) hi_n = cur - (WIDTH+1)'(1);
    if (resp == RESP_L) lo_n = cur + (WIDTH+1)'(1);
  end

  assign exhausted = (lo_n > hi_n);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = CALC;
      // An empty initial range falls out here, one cycle after acceptance.
      CALC: state_n = empty ? FIN : EVAL;
      EVAL: begin
        case (resp)
          RESP_Q:         state_n = FIN;
          RESP_G, RESP_L: state_n = exhausted ? FIN : CALC;
          default:        state_n = FIN;
        endcase
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      result <= '0;
      probes <= '0;
      busy   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= {lo_init[WIDTH-1], lo_init};
            hi     <= {hi_init[WIDTH-1], hi_init};
            found  <= 1'b0;
            err    <= 1'b0;
            probes <= '0;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          if (empty) result <= probe;
          else       probe  <= mid[WIDTH-1:0];
        end
        EVAL: begin
          probes <= probes + CW'(1);
          lo     <= lo_n;
          hi     <= hi_n;
          result <= probe;
          case (resp)
            RESP_Q:         found <= 1'b1;
            RESP_G, RESP_L: found <= 1'b0;
            default: begin
              found <= 1'b0;
              err   <= 1'b1;
            end
          endcase
        end
        FIN:     busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_search_sar.sv
// Directed bench for signed_search_sar with a behavioural signed comparator
// that can be overridden to inject illegal response patterns.
module tb_signed_search_sar;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] lo_init, hi_init;
  logic [7:0] probe;
  logic       cmp_g, cmp_q, cmp_l;
  logic       busy, done, found, err;
  logic [7:0] result;
  logic [3:0] probes;

  logic signed [7:0] target;
  logic signed [7:0] probe_s;
  logic              force_en;
  logic [2:0]        force_pat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_search_sar #(.WIDTH(8), .CW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .lo_init (lo_init),
    .hi_init (hi_init),
    .probe   (probe),
    .cmp_g   (cmp_g),
    .cmp_q   (cmp_q),
    .cmp_l   (cmp_l),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .err     (err),
    .result  (result),
    .probes  (probes)
  );

  assign probe_s = probe;
  assign {cmp_g, cmp_q, cmp_l} = force_en ? force_pat
                               : {probe_s > target, probe_s == target, probe_s < target};

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a search, follow every probe, and check the completion pulse and held results.
  task automatic run_search(input string name, input int lo, input int hi, input int tgt,
                            input int exp_p[9], input int n, input int exp_found,
                            input int exp_result, input bit keep_start);
    lo_init = 8'(lo);
    hi_init = 8'(hi);
    target  = 8'(tgt);
    start   = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
    check({name, "_busy_start"}, int'(busy), 1);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s_probe%0d", name, k + 1), int'(probe_s), exp_p[k]);
      check($sformatf("%s_nodone%0d", name, k + 1), int'(done), 0);
      tick();
    end
    check({name, "_done"},   int'(done),              1);
    check({name, "_found"},  int'(found),             exp_found);
    check({name, "_result"}, int'($signed(result)),   exp_result);
    check({name, "_probes"}, int'(probes),            n);
    check({name, "_err"},    int'(err),               0);
    check({name, "_busy_fin"}, int'(busy),            1);
    tick();
    check({name, "_done_low"},    int'(done),            0);
    check({name, "_busy_low"},    int'(busy),            0);
    check({name, "_found_held"},  int'(found),           exp_found);
    check({name, "_result_held"}, int'($signed(result)), exp_result);
    check({name, "_probe_held"},  int'(probe_s),         exp_p[n-1]);
  endtask

  initial begin
    int p_zero[9];
    int p_max[9];
    int p_min[9];
    int p_miss[9];

    p_zero = '{-1, 63, 31, 15, 7, 3, 1, 0, 0};
    p_max  = '{-1, 63, 95, 111, 119, 123, 125, 126, 127};
    p_min  = '{-1, -65, -97, -113, -121, -125, -127, -128, 0};
    p_miss = '{15, 12, 10, 0, 0, 0, 0, 0, 0};

    reset     = 1'b1;
    start     = 1'b0;
    lo_init   = '0;
    hi_init   = '0;
    target    = '0;
    force_en  = 1'b0;
    force_pat = 3'b000;
    tick();
    tick();
    check("rst_probe",  int'(probe),  0);
    check("rst_result", int'(result), 0);
    check("rst_probes", int'(probes), 0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_found",  int'(found),  0);
    check("rst_err",    int'(err),    0);
    reset = 1'b0;
    tick();

    run_search("full_t0",    -128, 127, 0,    p_zero, 8, 1, 0,    1'b0);
    run_search("full_t127",  -128, 127, 127,  p_max,  9, 1, 127,  1'b0);
    run_search("full_tm128", -128, 127, -128, p_min,  8, 1, -128, 1'b0);
    run_search("miss_low",   10,   20,  5,    p_miss, 3, 0, 10,   1'b0);

    // Empty range: completes in the second cycle after acceptance without probing.
    lo_init = 8'd5;
    hi_init = 8'd4;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("empty_nodone", int'(done), 0);
    tick();
    check("empty_done",   int'(done),   1);
    check("empty_found",  int'(found),  0);
    check("empty_probes", int'(probes), 0);
    check("empty_err",    int'(err),    0);
    tick();
    check("empty_done_low", int'(done), 0);
    check("empty_busy_low", int'(busy), 0);

    // Illegal comparator responses at the first EVAL.
    for (int t = 0; t < 2; t++) begin
      force_en  = 1'b1;
      force_pat = (t == 0) ? 3'b000 : 3'b110;
      lo_init   = 8'h80;
      hi_init   = 8'h7f;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check($sformatf("bad%0d_probe", t), int'(probe_s), -1);
      tick();
      check($sformatf("bad%0d_done", t),   int'(done),   1);
      check($sformatf("bad%0d_err", t),    int'(err),    1);
      check($sformatf("bad%0d_found", t),  int'(found),  0);
      check($sformatf("bad%0d_probes", t), int'(probes), 1);
      check($sformatf("bad%0d_result", t), int'(probe_s), int'($signed(result)));
      tick();
      check($sformatf("bad%0d_done_low", t), int'(done), 0);
      check($sformatf("bad%0d_err_held", t), int'(err),  1);
      tick();
      check($sformatf("bad%0d_single_pulse", t), int'(done), 0);
      force_en = 1'b0;
    end

    // Reset during the third EVAL of a full-range search.
    lo_init = 8'h80;
    hi_init = 8'h7f;
    target  = 8'sd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("abort_probe3", int'(probe_s), 31);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_probe",  int'(probe),  0);
    check("abort_result", int'(result), 0);
    check("abort_probes", int'(probes), 0);
    check("abort_busy",   int'(busy),   0);
    check("abort_done",   int'(done),   0);
    check("abort_found",  int'(found),  0);
    tick();
    check("abort_idle_done", int'(done), 0);
    check("abort_idle_busy", int'(busy), 0);
    run_search("after_abort", 10, 20, 5, p_miss, 3, 0, 10, 1'b0);

    // start held high: one done per search, the next search begins right after FIN.
    run_search("hold_a", -128, 127, 0,   p_zero, 8, 1, 0,   1'b1);
    run_search("hold_b", -128, 127, 127, p_max,  9, 1, 127, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("quiet_done%0d", k),   int'(done),            0);
      check($sformatf("quiet_result%0d", k), int'($signed(result)), 127);
      check($sformatf("quiet_probes%0d", k), int'(probes),          9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
